fsk_modulator: RTL and testbench
================================

// Module: fsk_modulator
// PURPOSE
//   Transmit-side peer of the zero-crossing demodulator. Serialises one 16-bit word
//   ({DATA_BYTE_1, DATA_BYTE_0}, MSB first) onto an 8-bit signed DAC sample stream.
//   Each bit occupies SAMPLES_PER_BIT clocks:
//   - '1' = constant +AMPLITUDE (no zero crossings).
//   - '0' = square carrier that toggles sign every HALF_PERIOD clocks.
//   Raises a maskable host interrupt at end of frame.
// PARAMETERS
//   SAMPLES_PER_BIT  32      clocks per data bit; must match receiver window; power of 2
//   HALF_PERIOD      4       clocks per carrier half-cycle for '0'; must divide SAMPLES_PER_BIT
//   AMPLITUDE        8'sd64  carrier magnitude; DAC swings +AMPLITUDE / -AMPLITUDE
//   PREAMBLE         8'hAA   sync pattern (used only with FSK_PREAMBLE_EN)
// PORTS
//   G_CLK_TX     in   1  transmit clock; all logic on posedge
//   reset        in   1  synchronous, active-high reset
//   DATA_BYTE_0  in   8  low data byte; sent second
//   DATA_BYTE_1  in   8  high data byte; sent first
//   tx_enable    in   1  global enable; low forces IDLE
//   tx_start     in   1  one-cycle start strobe
//   int_mask     in   1  1 = interrupt may reach host
//   int_clear    in   1  one-cycle strobe that clears int_flag
//   DAC          out  8  signed two's-complement sample; DAC[7] is sign
//   busy         out  1  frame in progress (STATUS)
//   int_flag     out  1  sticky end-of-frame flag (INTFLAG)
//   int_tx_host  out  1  int_flag & int_mask
// BEHAVIOUR
//   - Reset (sync, highest priority): state=IDLE, DAC=+AMPLITUDE, busy=0, int_flag=0,
//     all counters 0. Reset mid-frame aborts it immediately, with no interrupt.
//   - States:
//     - IDLE: DAC=+AMPLITUDE (mark level). tx_start & tx_enable at edge N latches
//       the 16-bit word into the shift register, -> SEND; busy=1 and the first
//       sample of bit 15 are on DAC from cycle N+1.
//     - SEND: sample counter s counts 0..SAMPLES_PER_BIT-1.
//       - Current bit '1': DAC=+AMPLITUDE.
//       - Current bit '0': DAC=+AMPLITUDE when (s/HALF_PERIOD) is even, else -AMPLITUDE.
//       - At s wrap: shift left by one, bit count +1.
//       - After the last sample of bit 0 -> IDLE, busy=0, int_flag=1 on the same edge.
//       - Frame length is exactly 16*SAMPLES_PER_BIT = 512 clocks.
//   - tx_start while busy: ignored; the latched word is not disturbed.
//   - Data inputs are sampled only on the accepted tx_start.
//   - tx_enable low during SEND: abort at the next edge -> IDLE, busy=0, int_flag unchanged.
//   - int_flag: set at frame end; cleared by int_clear. If set and clear land on the
//     same edge, set wins.
//   - int_tx_host is combinational from registered int_flag and int_mask.
//   - Counter widths: $clog2(SAMPLES_PER_BIT) bits for s; 5-bit bit counter (covers 24
//     bits with preamble); no wrap beyond the terminal count.
// CONFIGURATION
//   FSK_PREAMBLE_EN defined:
//     - PREAMBLE (8 bits, MSB first) is sent before the data word.
//     - Frame is 24 bits = 768 clocks; int_flag sets only after the final data bit.
//   FSK_PREAMBLE_EN undefined:
//     - 16-bit frame as above; no preamble logic is synthesised.
// STRUCTURE
//   fsk_pkg:
//     - tx_state_t enum {IDLE, SEND}
//     - DEFAULT_SAMPLES_PER_BIT, DEFAULT_AMPLITUDE, FRAME_BITS constants
//     - shared with the demodulator
//   Sub-module fsk_tone_gen:
//     - inputs: bit value, sample counter s
//     - output: DAC sample
//     - pure function of its inputs, registered in the parent
//   Parent holds the FSM, shift register, counters and interrupt logic.
// TESTING
//   1. Reset, then idle 10 clocks -> DAC=8'h40, busy=0, int_tx_host=0.
//   2. DATA_BYTE_1=8'hFF, DATA_BYTE_0=8'h00, start at cycle 0 -> DAC:
//      - cycles 1..256: constant 8'h40.
//      - cycles 257..512: alternates 8'h40/8'hC0 every 4 clocks.
//      - busy falls at cycle 513.
//   3. Word 16'hA5C3 with int_mask=1 -> looped-back demodulator decodes 8'hA5/8'hC3;
//      int_tx_host=1 at cycle 513 and stays high until int_clear.
//   4. Second tx_start at cycle 100 of a frame with different data -> ignored; the
//      original word completes, ending at cycle 513.
//   5. tx_enable dropped at cycle 200 -> IDLE at 201, DAC=8'h40, int_flag=0.
//      Reset at cycle 300 of a new frame -> same result.
//   6. int_clear coincident with the frame-end edge -> int_flag=1.
//      With FSK_PREAMBLE_EN: frame is 768 clocks; first 32 clocks are DAC=8'h40 (PREAMBLE MSB=1).

Source files
------------

// File: rtl/fsk_pkg.sv
// Shared FSK definitions: FSM states, default tone parameters and frame length.
// FSK_PREAMBLE_EN extends the frame with an 8-bit sync preamble.
package fsk_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

  localparam int unsigned DEFAULT_SAMPLES_PER_BIT = 32;
  localparam int unsigned DEFAULT_HALF_PERIOD     = 4;
  localparam logic signed [7:0] DEFAULT_AMPLITUDE = 8'sd64;
  localparam logic [7:0]  DEFAULT_PREAMBLE        = 8'hAA;
  localparam int unsigned DATA_BITS               = 16;

`ifdef FSK_PREAMBLE_EN
  localparam int unsigned FRAME_BITS = DATA_BITS + 8;
`else
  localparam int unsigned FRAME_BITS = DATA_BITS;
`endif

endpackage

// File: rtl/fsk_modulator_if.sv
// Host-side bundle of the FSK modulator: data, control, DAC stream and interrupt.
interface fsk_modulator_if;
  logic [7:0] DATA_BYTE_0;
  logic [7:0] DATA_BYTE_1;
  logic       tx_enable;
  logic       tx_start;
  logic       int_mask;
  logic       int_clear;
  logic [7:0] DAC;
  logic       busy;
  logic       int_flag;
  logic       int_tx_host;

  modport master (
    output DATA_BYTE_0, DATA_BYTE_1, tx_enable, tx_start, int_mask, int_clear,
    input  DAC, busy, int_flag, int_tx_host
  );

  modport slave (
    input  DATA_BYTE_0, DATA_BYTE_1, tx_enable, tx_start, int_mask, int_clear,
    output DAC, busy, int_flag, int_tx_host
  );
endinterface

// File: rtl/fsk_tone_gen.sv
// Combinational tone generator: maps (bit value, sample index) to a DAC sample.
// '1' holds the mark level; '0' is a square carrier toggling every HALF_PERIOD samples.
module fsk_tone_gen #(
  parameter int unsigned       SAMPLES_PER_BIT = 32,
  parameter int unsigned       HALF_PERIOD     = 4,
  parameter logic signed [7:0] AMPLITUDE       = 8'sd64
) (
  input  logic                               i_bit,
  input  logic [$clog2(SAMPLES_PER_BIT)-1:0] i_s,
  output logic [7:0]                         o_sample
);
  localparam int unsigned SW      = $clog2(SAMPLES_PER_BIT);
  localparam logic [7:0]  POS_LVL = AMPLITUDE;
  localparam logic [7:0]  NEG_LVL = 8'(-AMPLITUDE);

  logic w_phase;

  // Odd half-cycles of the carrier are the negative swing.
  assign w_phase  = 1'(i_s / SW'(HALF_PERIOD));
  assign o_sample = (i_bit || !w_phase) ? POS_LVL : NEG_LVL;
endmodule

// File: rtl/fsk_modulator.sv
// FSK transmitter: serialises {DATA_BYTE_1, DATA_BYTE_0} MSB first onto the DAC stream
// and flags end of frame. FSK_PREAMBLE_EN prepends an 8-bit preamble.
module fsk_modulator
  import fsk_pkg::*;
#(
  parameter int unsigned       SAMPLES_PER_BIT = DEFAULT_SAMPLES_PER_BIT,
  parameter int unsigned       HALF_PERIOD     = DEFAULT_HALF_PERIOD,
  parameter logic signed [7:0] AMPLITUDE       = DEFAULT_AMPLITUDE
`ifdef FSK_PREAMBLE_EN
  ,
  parameter logic [7:0]        PREAMBLE        = DEFAULT_PREAMBLE
`endif
) (
  input logic            G_CLK_TX,
  input logic            reset,
  fsk_modulator_if.slave tx_if
);
  localparam int unsigned SW  = $clog2(SAMPLES_PER_BIT);
  localparam int unsigned BCW = 5;

  tx_state_t             r_state;
  logic [FRAME_BITS-1:0] r_shift;
  logic [SW-1:0]         r_s;
  logic [BCW-1:0]        r_bitcnt;
  logic [7:0]            r_dac;
  logic                  r_busy;
  logic                  r_int_flag;

  logic [FRAME_BITS-1:0] w_load_word;
  logic [FRAME_BITS-1:0] w_shift_nxt;
  logic [SW-1:0]         w_s_nxt;
  logic [SW-1:0]         w_tone_s;
  logic                  w_tone_bit;
  logic [7:0]            w_tone;
  logic                  w_start;
  logic                  w_s_wrap;
  logic                  w_last;

`ifdef FSK_PREAMBLE_EN
  assign w_load_word = {PREAMBLE, tx_if.DATA_BYTE_1, tx_if.DATA_BYTE_0};
`else
  assign w_load_word = {tx_if.DATA_BYTE_1, tx_if.DATA_BYTE_0};
`endif

  assign w_start     = (r_state == IDLE) && tx_if.tx_start && tx_if.tx_enable;
  assign w_s_wrap    = (r_s == SW'(SAMPLES_PER_BIT - 1));
  assign w_last      = w_s_wrap && (r_bitcnt == BCW'(FRAME_BITS - 1));
  assign w_s_nxt     = w_s_wrap ? '0 : r_s + SW'(1);
  assign w_shift_nxt = w_s_wrap ? {r_shift[FRAME_BITS-2:0], 1'b0} : r_shift;

  // The tone is evaluated for the sample that will be on the DAC after this edge.
  assign w_tone_bit  = w_start ? w_load_word[FRAME_BITS-1] : w_shift_nxt[FRAME_BITS-1];
  assign w_tone_s    = w_start ? '0 : w_s_nxt;

  fsk_tone_gen #(
    .SAMPLES_PER_BIT (SAMPLES_PER_BIT),
    .HALF_PERIOD     (HALF_PERIOD),
    .AMPLITUDE       (AMPLITUDE)
  ) u_tone_gen (
    .i_bit    (w_tone_bit),
    .i_s      (w_tone_s),
    .o_sample (w_tone)
  );

  always_ff @(posedge G_CLK_TX) begin
    if (reset) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_s        <= '0;
      r_bitcnt   <= '0;
      r_dac      <= AMPLITUDE;
      r_busy     <= 1'b0;
      r_int_flag <= 1'b0;
    end else begin
      // A frame-end set below overrides a coincident clear.
      if (tx_if.int_clear) r_int_flag <= 1'b0;
      case (r_state)
        IDLE: begin
          r_dac  <= AMPLITUDE;
          r_busy <= 1'b0;
          if (w_start) begin
            r_state  <= SEND;
            r_shift  <= w_load_word;
            r_s      <= '0;
            r_bitcnt <= '0;
            r_dac    <= w_tone;
            r_busy   <= 1'b1;
          end
        end
        SEND: begin
          if (!tx_if.tx_enable || w_last) begin
            r_state  <= IDLE;
            r_s      <= '0;
            r_bitcnt <= '0;
            r_dac    <= AMPLITUDE;
            r_busy   <= 1'b0;
            if (tx_if.tx_enable) r_int_flag <= 1'b1;
          end else begin
            r_s     <= w_s_nxt;
            r_shift <= w_shift_nxt;
            r_dac   <= w_tone;
            if (w_s_wrap) r_bitcnt <= r_bitcnt + BCW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tx_if.DAC         = r_dac;
  assign tx_if.busy        = r_busy;
  assign tx_if.int_flag    = r_int_flag;
  assign tx_if.int_tx_host = r_int_flag & tx_if.int_mask;
endmodule

// File: tb/tb_fsk_modulator.sv
// Scoreboard bench for fsk_modulator: expected DAC samples are queued at frame start
// and popped against the DUT stream every clock; a local decoder recovers the word.
module tb_fsk_modulator;
  import fsk_pkg::*;

  localparam int unsigned SPB        = 32;
  localparam int unsigned HP         = 4;
  localparam int unsigned FB         = FRAME_BITS;
  localparam int unsigned FRAME_CLKS = FB * SPB;

  localparam int ACT_NONE   = 0;
  localparam int ACT_START2 = 1;
  localparam int ACT_DISABL = 2;
  localparam int ACT_RESET  = 3;
  localparam int ACT_CLEAR  = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [7:0]    exp_q[$];
  logic [FB-1:0] rx_neg;

  always #5 clk = ~clk;

  fsk_modulator_if tx_if ();

  fsk_modulator dut (
    .G_CLK_TX (clk),
    .reset    (rst),
    .tx_if    (tx_if)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_sample(input logic b, input int s);
    if (b) return 8'h40;
    return (((s / HP) % 2) == 0) ? 8'h40 : 8'hC0;
  endfunction

  task automatic push_frame(input logic [15:0] w);
    logic [FB-1:0] f;
`ifdef FSK_PREAMBLE_EN
    f = {8'hAA, w};
`else
    f = w;
`endif
    for (int i = 0; i < int'(FB); i++)
      for (int s = 0; s < int'(SPB); s++)
        exp_q.push_back(model_sample(f[FB-1-i], s));
  endtask

  // Drive a start strobe on the next edge and queue the expected sample stream.
  task automatic start_frame(input logic [7:0] b1, input logic [7:0] b0);
    @(negedge clk);
    tx_if.DATA_BYTE_1 = b1;
    tx_if.DATA_BYTE_0 = b0;
    tx_if.tx_start    = 1'b1;
    push_frame({b1, b0});
  endtask

  // Compare n cycles of output; optionally inject an event after cycle act_cycle.
  task automatic drain(input int n, input int act_cycle, input int act_kind);
    logic [7:0] e;
    rx_neg = '0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      tx_if.tx_start  = 1'b0;
      tx_if.int_clear = 1'b0;
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'(k), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("dac", 32'(tx_if.DAC), 32'(e));
        check("busy", 32'(tx_if.busy), 32'(1));
        if (tx_if.DAC[7]) rx_neg[FB - 1 - ((k - 1) / SPB)] = 1'b1;
      end
      if (k == act_cycle) begin
        case (act_kind)
          ACT_START2: begin
            tx_if.DATA_BYTE_1 = 8'h0F;
            tx_if.DATA_BYTE_0 = 8'hF0;
            tx_if.tx_start    = 1'b1;
          end
          ACT_DISABL: begin tx_if.tx_enable = 1'b0; return; end
          ACT_RESET:  begin rst = 1'b1; return; end
          ACT_CLEAR:  tx_if.int_clear = 1'b1;
          default: ;
        endcase
      end
    end
  endtask

  task automatic end_check(input logic exp_flag, input logic exp_host);
    @(negedge clk);
    tx_if.int_clear = 1'b0;
    check("end_busy", 32'(tx_if.busy), 32'(0));
    check("end_dac", 32'(tx_if.DAC), 32'h40);
    check("end_flag", 32'(tx_if.int_flag), 32'(exp_flag));
    check("end_host", 32'(tx_if.int_tx_host), 32'(exp_host));
    check("sb_leftover", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic clear_flag();
    @(negedge clk);
    tx_if.int_clear = 1'b1;
    @(negedge clk);
    tx_if.int_clear = 1'b0;
    check("clr_flag", 32'(tx_if.int_flag), 32'(0));
    check("clr_host", 32'(tx_if.int_tx_host), 32'(0));
  endtask

  task automatic abort_check(input string tag);
    @(negedge clk);
    rst             = 1'b0;
    tx_if.tx_enable = 1'b1;
    exp_q.delete();
    check({tag, "_busy"}, 32'(tx_if.busy), 32'(0));
    check({tag, "_dac"}, 32'(tx_if.DAC), 32'h40);
    check({tag, "_flag"}, 32'(tx_if.int_flag), 32'(0));
    repeat (3) @(negedge clk);
    check({tag, "_idle_dac"}, 32'(tx_if.DAC), 32'h40);
  endtask

  initial begin
    logic [15:0] decoded;
    logic [15:0] want;
    rst               = 1'b1;
    tx_if.DATA_BYTE_0 = 8'h00;
    tx_if.DATA_BYTE_1 = 8'h00;
    tx_if.tx_enable   = 1'b1;
    tx_if.tx_start    = 1'b0;
    tx_if.int_mask    = 1'b0;
    tx_if.int_clear   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state after 10 idle clocks.
    repeat (10) @(negedge clk);
    check("rst_dac", 32'(tx_if.DAC), 32'h40);
    check("rst_busy", 32'(tx_if.busy), 32'(0));
    check("rst_flag", 32'(tx_if.int_flag), 32'(0));
    check("rst_host", 32'(tx_if.int_tx_host), 32'(0));

    // All-ones then all-zeros, interrupt masked.
    start_frame(8'hFF, 8'h00);
    drain(FRAME_CLKS, 0, ACT_NONE);
    end_check(1'b1, 1'b0);
    clear_flag();

    // Mixed word with interrupt unmasked; decode and hold interrupt until cleared.
    tx_if.int_mask = 1'b1;
    start_frame(8'hA5, 8'hC3);
    drain(FRAME_CLKS, 0, ACT_NONE);
    decoded = ~rx_neg[15:0];
    want    = 16'hA5C3;
    check("decode", 32'(decoded), 32'(want));
    end_check(1'b1, 1'b1);
    repeat (5) @(negedge clk);
    check("host_hold", 32'(tx_if.int_tx_host), 32'(1));
    clear_flag();

    // Second start mid-frame is ignored.
    start_frame(8'h12, 8'h34);
    drain(FRAME_CLKS, 100, ACT_START2);
    end_check(1'b1, 1'b1);
    clear_flag();

    // Enable dropped mid-frame aborts without interrupt.
    start_frame(8'h5A, 8'h3C);
    drain(FRAME_CLKS, 200, ACT_DISABL);
    abort_check("dis");

    // Reset mid-frame aborts without interrupt.
    start_frame(8'h69, 8'h96);
    drain(FRAME_CLKS, 300, ACT_RESET);
    abort_check("rst");

    // Clear coincident with the frame-end edge: set wins.
    start_frame(8'h00, 8'hFF);
    drain(FRAME_CLKS, FRAME_CLKS, ACT_CLEAR);
    end_check(1'b1, 1'b1);
    clear_flag();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
